// File: rtl/lsu_pkg.sv
// lsu_pkg: load kinds, store masks and FSM encoding shared by the memory-access stage
package lsu_pkg;
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [3:0] SM_NONE = 4'b0000;
    localparam logic [3:0] SM_B    = 4'b0001;
    localparam logic [3:0] SM_H    = 4'b0011;
    localparam logic [3:0] SM_W    = 4'b1111;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/lsu_ldfmt.sv
// lsu_ldfmt: aligns a read word to the accessed byte lane and sign/zero-extends it
module lsu_ldfmt
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            off,
    input  logic [2:0]            kind,
    output logic [DATA_WIDTH-1:0] data
);
    logic [DATA_WIDTH-1:0] sh;
    // shift the addressed lane down, then extend by load kind (lw keeps the raw word)
    always_comb begin
        sh   = rdata >> {off, 3'b000};
        data = kind == LD_LB  ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
               kind == LD_LBU ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
               kind == LD_LH  ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
               kind == LD_LHU ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/lsu.sv
// lsu: memory-access stage running one data-memory transaction per load/store
module lsu
    import lsu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      e_regW,
    input  logic [REG_ADDR_WIDTH-1:0] e_regAddr,
    input  logic [DATA_WIDTH-1:0]     e_regData,
    input  logic [2:0]                e_load_inst,
    input  logic [3:0]                e_store_mask,
    input  logic [DATA_WIDTH-1:0]     e_store_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_wen,
    output logic [DATA_WIDTH-1:0]     mem_req_addr,
    output logic [3:0]                mem_req_wmask,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
    output logic                      m_valid,
    output logic                      m_regW,
    output logic [REG_ADDR_WIDTH-1:0] m_regAddr,
    output logic [DATA_WIDTH-1:0]     m_regData,
    output logic                      m_misalign
);
    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d, sdata_q, sdata_d, m_regdata_q, m_regdata_d;
    logic [2:0]                kind_q, kind_d;
    logic [3:0]                mask_q, mask_d;
    logic                      st_q, st_d, regw_q, regw_d, m_regw_q, m_regw_d, m_mis_q, m_mis_d;
    logic [REG_ADDR_WIDTH-1:0] regaddr_q, regaddr_d, m_regaddr_q, m_regaddr_d;
    logic                      is_st, is_ld, mis;
    logic [DATA_WIDTH-1:0]     ld_data;

    lsu_ldfmt #(.DATA_WIDTH(DATA_WIDTH)) u_ldfmt (
        .rdata(mem_rsp_rdata),
        .off  (addr_q[1:0]),
        .kind (kind_q),
        .data (ld_data)
    );

    // classify the offered instruction; a store mask overrides any load kind
    always_comb begin
        is_st = e_store_mask != SM_NONE;
        is_ld = !is_st && e_load_inst >= LD_LB && e_load_inst <= LD_LW;
        mis   = is_st ? (e_store_mask == SM_H && e_regData[0]) ||
                        (e_store_mask == SM_W && e_regData[1:0] != 2'b00)
                      : is_ld && (((e_load_inst == LD_LH || e_load_inst == LD_LHU) && e_regData[0]) ||
                                  (e_load_inst == LD_LW && e_regData[1:0] != 2'b00));
    end

    // FSM next state plus latch updates; writeback fields change only on entry to DONE
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        kind_d      = kind_q;
        mask_d      = mask_q;
        st_d        = st_q;
        regw_d      = regw_q;
        regaddr_d   = regaddr_q;
        m_regdata_d = m_regdata_q;
        m_regw_d    = m_regw_q;
        m_mis_d     = m_mis_q;
        m_regaddr_d = m_regaddr_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                addr_d    = e_regData;
                sdata_d   = e_store_data;
                mask_d    = e_store_mask;
                st_d      = is_st;
                kind_d    = is_ld ? e_load_inst : LD_NONE;
                regw_d    = e_regW;
                regaddr_d = e_regAddr;
                if ((is_st || is_ld) && !mis) begin
                    state_d = S_REQ;
                end else begin
                    state_d     = S_DONE;
                    m_regdata_d = e_regData;
                    m_regw_d    = e_regW && !mis;
                    m_mis_d     = mis;
                    m_regaddr_d = e_regAddr;
                end
            end
            S_REQ: state_d = mem_req_ready ? S_WAIT : S_REQ;
            S_WAIT: if (mem_rsp_valid) begin
                state_d     = S_DONE;
                m_regdata_d = st_q ? addr_q : ld_data;
                m_regw_d    = regw_q && !st_q;
                m_mis_d     = 1'b0;
                m_regaddr_d = regaddr_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and latched-instruction registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            kind_q      <= LD_NONE;
            mask_q      <= SM_NONE;
            st_q        <= 1'b0;
            regw_q      <= 1'b0;
            regaddr_q   <= '0;
            m_regdata_q <= '0;
            m_regw_q    <= 1'b0;
            m_mis_q     <= 1'b0;
            m_regaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            kind_q      <= kind_d;
            mask_q      <= mask_d;
            st_q        <= st_d;
            regw_q      <= regw_d;
            regaddr_q   <= regaddr_d;
            m_regdata_q <= m_regdata_d;
            m_regw_q    <= m_regw_d;
            m_mis_q     <= m_mis_d;
            m_regaddr_q <= m_regaddr_d;
        end
    end

    assign in_ready      = rst_n && state_q == S_IDLE;
    assign mem_req_valid = state_q == S_REQ;
    assign mem_req_wen   = st_q;
    assign mem_req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_req_wmask = st_q ? mask_q << addr_q[1:0] : 4'b0000;
    assign mem_req_wdata = st_q ? sdata_q << {addr_q[1:0], 3'b000} : '0;
    assign m_valid       = state_q == S_DONE;
    assign m_regW        = m_regw_q;
    assign m_regAddr     = m_regaddr_q;
    assign m_regData     = m_regdata_q;
    assign m_misalign    = m_mis_q;
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Accepts one executed instruction per handshake: register-write intent, ALU result (the address for memory ops), load kind, store mask and store data.
- For loads and stores, runs one transaction on the data-memory request/response bus. Loads are aligned and sign/zero-extended; the result is presented to writeback as a one-cycle pulse.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, data/address width; byte-lane logic fixed at 4 lanes

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  lsu can accept (high only in IDLE)
- e_regW  in  1  instruction writes a register
- e_regAddr  in  REG_ADDR_WIDTH  destination register
- e_regData  in  DATA_WIDTH  ALU result / memory byte address
- e_load_inst  in  3  load kind: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6-7 treated as none
- e_store_mask  in  4  unshifted byte mask: 0000 none, 0001 sb, 0011 sh, 1111 sw
- e_store_data  in  DATA_WIDTH  unshifted rs2 value
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  1 = write
- mem_req_addr  out  DATA_WIDTH  word-aligned address (low 2 bits 0)
- mem_req_wmask  out  4  shifted byte-lane mask (0 for reads)
- mem_req_wdata  out  DATA_WIDTH  lane-shifted store data
- mem_rsp_valid  in  1  read data / write ack
- mem_rsp_rdata  in  DATA_WIDTH  read word
- m_valid  out  1  one-cycle writeback pulse
- m_regW  out  1  write enable (valid with m_valid)
- m_regAddr  out  REG_ADDR_WIDTH  destination register
- m_regData  out  DATA_WIDTH  load result or passed-through ALU result
- m_misalign  out  1  misaligned access flagged (valid with m_valid)

Behaviour:
- Reset: all state and outputs 0 immediately on rst_n low (asynchronous); FSM goes to IDLE; in_ready=1 once rst_n is high. Reset mid-transaction abandons it and emits no m_valid.
- The request is a store if store_mask≠0. It is a load if load_inst∈1..5. If both are set, the store wins and the load is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on in_valid, latch all inputs.
    - Non-memory instruction: go to DONE.
    - Misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0): go to DONE with m_misalign=1 and m_regW forced 0; no bus request is issued.
    - Otherwise: go to REQ.
  - REQ: mem_req_valid=1 with stable fields until the handshake. On mem_req_ready go to WAIT.
  - WAIT: on mem_rsp_valid, latch the formatted result (loads) or simply complete (stores), then go to DONE. A mem_rsp_valid seen outside WAIT is ignored.
  - DONE: m_valid=1 for exactly one cycle, then go to IDLE. m_* fields hold their value until the next DONE.
- Latency with acceptance at cycle T:
  - Pass-through and misaligned: m_valid at T+1.
  - Memory access with immediate ready and response one cycle later: m_valid at T+3. Each extra stall cycle adds one.
- Store formatting:
  - wmask = store_mask << addr[1:0].
  - wdata = store_data << (8*addr[1:0]).
  - wen=1.
- Load formatting: from rdata >> (8*addr[1:0]), take bits [7:0] or [15:0] and sign/zero-extend per kind; lw takes the whole word. wen=0, wmask=0.
- m_regData:
  - Loads: the formatted data.
  - Everything else: the latched e_regData.
- m_regW:
  - Stores: forced 0.
  - Otherwise: the latched e_regW (misaligned accesses already forced 0 as above).
- Only one instruction is in flight; in_ready=0 in REQ/WAIT/DONE.

Decomposition:
- Shared package contents:
  - load-kind constants (LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW);
  - store-mask constants;
  - FSM state encoding.
- Sub-module lsu_ldfmt (combinational): inputs rdata, addr[1:0], load kind; output extended data.

Test Plan:
- Pass-through: e_regData=0x1234, e_regW=1, regAddr=5, no mem op -> m_valid at T+1 with m_regData=0x1234, m_regAddr=5; no mem_req_valid.
- lb at address 0x80000003, rsp 0x80FF_0000 -> mem_req_addr=0x80000000, wen=0; m_regData=0xFFFFFF80. Same with lbu -> 0x00000080.
- sh data 0xABCD1234 at 0x102 -> wmask=1100, wdata=0x12340000, wen=1; after ack m_valid with m_regW=0.
- lw at 0x101 -> m_misalign=1, m_regW=0 at T+1; mem_req_valid never asserted.
- Backpressure: mem_req_ready low for 3 cycles, rsp 2 cycles later -> request fields stable throughout; m_valid at T+7; in_ready low until the cycle after m_valid.
- rst_n pulsed low while in WAIT -> outputs 0 immediately; a later mem_rsp_valid is ignored; no m_valid.
